// File: rtl/dmem_access.sv
// dmem_access: data-memory access stage backed by a block-RAM array.
// After reset a clear sequencer zeroes every word before accesses are accepted.
module dmem_access #(
    parameter int dm_addr_width = 10,
    parameter int datawidth     = 32,
    parameter int dest_width    = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [dm_addr_width-1:0] addr_datamem_i,
    input  logic [datawidth-1:0]     data_datamem_i,
    input  logic [dest_width-1:0]    dest_i,
    output logic [datawidth-1:0]     load_data_o,
    output logic                     load_valid_o,
    output logic [dest_width-1:0]    load_dest_o,
    output logic                     busy_o,
    output logic                     err_o
);

    localparam int depth = 1 << dm_addr_width;

    typedef logic [dm_addr_width:0] cnt_t;
    localparam cnt_t cnt_last = cnt_t'(depth - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t state;
    state_t state_nxt;
    cnt_t   cnt;

    logic [datawidth-1:0]     mem [depth];
    logic                     mem_we;
    logic [dm_addr_width-1:0] mem_waddr;
    logic [datawidth-1:0]     mem_wdata;

    logic                     ready;
    logic                     is_store;
    logic                     is_load;
    logic                     is_illegal;

    logic                     acc_valid;
    logic                     acc_err;
    logic [dm_addr_width-1:0] acc_addr;
    logic [dest_width-1:0]    acc_dest;

    logic                     rd_valid;
    logic [datawidth-1:0]     rd_data;
    logic [dest_width-1:0]    rd_dest;

    assign ready      = (state == READY);
    assign is_store   = en_i & we_i & ~re_i;
    assign is_load    = en_i & re_i & ~we_i;
    assign is_illegal = en_i & we_i & re_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        unique case (state)
            CLEAR: begin
                busy_o = 1'b1;
                if (cnt == cnt_last) begin
                    state_nxt = READY;
                end
            end
            READY: begin
                state_nxt = READY;
            end
            default: begin
                state_nxt = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == CLEAR) begin
            cnt <= cnt + cnt_t'(1);
        end
    end

    // Single write port shared by the clear sweep and stores.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = addr_datamem_i;
        mem_wdata = data_datamem_i;
        if (state == CLEAR) begin
            mem_we    = ~rst;
            mem_waddr = cnt[dm_addr_width-1:0];
            mem_wdata = '0;
        end else begin
            mem_we = ~rst & is_store;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        acc_addr <= addr_datamem_i;
        rd_data  <= mem[acc_addr];
    end

    // Accept register, BRAM read register, then output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_valid    <= 1'b0;
            acc_err      <= 1'b0;
            acc_dest     <= '0;
            rd_valid     <= 1'b0;
            rd_dest      <= '0;
            load_valid_o <= 1'b0;
            load_data_o  <= '0;
            load_dest_o  <= '0;
            err_o        <= 1'b0;
        end else begin
            acc_valid    <= ready & is_load;
            acc_err      <= ready & is_illegal;
            acc_dest     <= dest_i;
            rd_valid     <= acc_valid;
            rd_dest      <= acc_dest;
            load_valid_o <= rd_valid;
            err_o        <= acc_err;
            if (rd_valid) begin
                load_data_o <= rd_data;
                load_dest_o <= rd_dest;
            end
        end
    end

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: directed table, corner sequences and random traffic
// checked against a timestamped reference model of dmem_access.
module tb_dmem_access;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int TW    = 5;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en  = 1'b0;
    logic          we  = 1'b0;
    logic          re  = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] data = '0;
    logic [TW-1:0] dest = '0;

    logic [DW-1:0] load_data_o;
    logic          load_valid_o;
    logic [TW-1:0] load_dest_o;
    logic          busy_o;
    logic          err_o;

    dmem_access #(
        .dm_addr_width(AW),
        .datawidth    (DW),
        .dest_width   (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en_i          (en),
        .we_i          (we),
        .re_i          (re),
        .addr_datamem_i(addr),
        .data_datamem_i(data),
        .dest_i        (dest),
        .load_data_o   (load_data_o),
        .load_valid_o  (load_valid_o),
        .load_dest_o   (load_dest_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } ld_t;

    typedef struct {
        logic          we;
        logic          re;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
        logic [DW-1:0] ed;
    } vec_t;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            clear_left = DEPTH;
    logic [DW-1:0] mdl_mem [DEPTH];
    ld_t           ld_q[$];
    int            err_q[$];
    ld_t           got_q[$];
    vec_t          tbl[$];
    int            exp_due[$];
    logic [DW-1:0] exp_d[$];
    logic [TW-1:0] exp_t[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Drive one cycle, advance the model at the edge, check at the negedge.
    task automatic step(input logic r, input logic e, input logic w,
                        input logic rd, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [TW-1:0] t);
        logic ev;
        logic ee;
        rst  = r;
        en   = e;
        we   = w;
        re   = rd;
        addr = a;
        data = d;
        dest = t;
        @(posedge clk);
        cyc++;
        if (r) begin
            clear_left = DEPTH;
            ld_q.delete();
            err_q.delete();
            foreach (mdl_mem[i]) mdl_mem[i] = '0;
        end else if (clear_left > 0) begin
            clear_left--;
        end else if (e) begin
            if (w && rd) err_q.push_back(cyc + 1);
            else if (w) mdl_mem[a] = d;
            else if (rd) ld_q.push_back('{cyc + 2, mdl_mem[a], t});
        end
        @(negedge clk);
        ev = (ld_q.size() > 0) && (ld_q[0].due == cyc);
        chk("load_valid", load_valid_o, ev);
        if (ev) begin
            chk("load_data", load_data_o, ld_q[0].d);
            chk("load_dest", load_dest_o, ld_q[0].t);
            void'(ld_q.pop_front());
        end
        if (load_valid_o) got_q.push_back('{cyc, load_data_o, load_dest_o});
        ee = (err_q.size() > 0) && (err_q[0] == cyc);
        chk("err", err_o, ee);
        if (ee) void'(err_q.pop_front());
        chk("busy", busy_o, clear_left > 0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic wait_clear(output int k);
        k = 0;
        while (busy_o && k < 40) begin
            idle();
            k++;
        end
    endtask

    task automatic add(input logic w, input logic r, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [TW-1:0] t,
                       input logic [DW-1:0] ed);
        tbl.push_back('{w, r, a, d, t, ed});
    endtask

    initial begin
        int k;

        add(1, 0, 5, 32'hDEADBEEF, 0, 0);
        add(0, 1, 5, 0, 7, 32'hDEADBEEF);
        for (int i = 0; i < 4; i++) add(1, 0, AW'(i), DW'(i * 32'h11), 0, 0);
        for (int i = 0; i < 4; i++)
            add(0, 1, AW'(3 - i), 0, TW'(i + 1), DW'((3 - i) * 32'h11));
        add(1, 1, 2, 32'hFF, 0, 0);
        add(0, 1, 2, 0, 9, 32'h22);
        add(1, 0, 15, 32'hFFFFFFFF, 0, 0);
        add(0, 1, 15, 0, 31, 32'hFFFFFFFF);
        add(0, 1, 14, 0, 0, 32'h0);
        add(0, 0, 9, 32'h77, 0, 0);

        // reset held three cycles
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        chk("rst_data", load_data_o, 0);
        chk("rst_dest", load_dest_o, 0);
        chk("rst_busy", busy_o, 1);

        // clear sweep, with a store attempted while busy
        k = 0;
        while (busy_o && k < 40) begin
            if (k == 3) step(1'b0, 1'b1, 1'b1, 1'b0, 3, 32'hAA, 0);
            else idle();
            k++;
        end
        chk("clear_len", k, 16);

        got_q.delete();
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, 1'b1, 1'b0, 1'b1, AW'(i), '0, TW'(i));
        idle();
        idle();
        chk("sweep_n", got_q.size(), DEPTH);
        for (int i = 0; i < got_q.size(); i++) begin
            chk("sweep_data", got_q[i].d, 0);
            chk("sweep_dest", got_q[i].t, i);
            chk("sweep_back2back", got_q[i].due, got_q[0].due + i);
        end

        // directed table
        got_q.delete();
        foreach (tbl[i]) begin
            step(1'b0, 1'b1, tbl[i].we, tbl[i].re, tbl[i].a, tbl[i].d,
                 tbl[i].t);
            if (tbl[i].re && !tbl[i].we) begin
                exp_due.push_back(cyc + 2);
                exp_d.push_back(tbl[i].ed);
                exp_t.push_back(tbl[i].t);
            end
        end
        for (int i = 0; i < 3; i++) idle();
        chk("tbl_nloads", got_q.size(), exp_d.size());
        for (int i = 0; i < exp_d.size() && i < got_q.size(); i++) begin
            chk("tbl_data", got_q[i].d, exp_d[i]);
            chk("tbl_dest", got_q[i].t, exp_t[i]);
            chk("tbl_latency", got_q[i].due, exp_due[i]);
        end

        // random traffic against the model
        for (int i = 0; i < 500; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if ($urandom_range(0, 149) == 0)
                step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
            else
                step(1'b0, op != 0, op inside {[1:3], 9}, op inside {[4:8], 9},
                     AW'($urandom), DW'($urandom), TW'($urandom));
        end
        wait_clear(k);

        // reset kills an in-flight load and restarts the clear
        step(1'b0, 1'b1, 1'b1, 1'b0, 5, 32'h5A5A5A5A, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 5, 0, 3);
        got_q.delete();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        wait_clear(k);
        chk("clear_after_kill", k, 16);
        chk("killed_load", got_q.size(), 0);

        // reset again mid-clear at cnt = 9
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        for (int i = 0; i < 9; i++) idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        wait_clear(k);
        chk("clear_restart", k, 16);

        got_q.delete();
        step(1'b0, 1'b1, 1'b0, 1'b1, 5, 0, 6);
        idle();
        idle();
        chk("post_clear_n", got_q.size(), 1);
        if (got_q.size() > 0) chk("post_clear_data", got_q[0].d, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_access.md
# dmem_access

Data-memory access stage that sits directly downstream of the address/offset stage. Each cycle it takes one registered access (address, store data, load/store command, destination register tag), performs it against an on-chip block-RAM data memory, and returns load results with their destination tag to writeback. After every reset, a clear sequencer zeroes the whole memory before accesses are accepted.

## Interface
Parameters:
- dm_addr_width, default `dm_addr_width` (10): address width; memory depth is 2^dm_addr_width words.
- datawidth, default `datawidth` (32): word width.
- dest_width, default 5: destination-register tag width.

Ports:
- clk  input  1  clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en_i  input  1  access valid this cycle.
- we_i  input  1  store command; qualified by en_i.
- re_i  input  1  load command; qualified by en_i.
- addr_datamem_i  input  dm_addr_width  word address.
- data_datamem_i  input  datawidth  store data.
- dest_i  input  dest_width  destination tag for a load.
- load_data_o  output  datawidth  load result.
- load_valid_o  output  1  load_data_o/load_dest_o valid; one-cycle pulse per load.
- load_dest_o  output  dest_width  tag of the returning load.
- busy_o  output  1  clear sequence in progress; accesses are ignored.
- err_o  output  1  one-cycle pulse: illegal command (we_i and re_i both set).

## Operation
- FSM states: CLEAR and READY. rst forces CLEAR, resets the clear counter to 0 and suppresses memory writes while rst is high.
- CLEAR: each cycle after rst falls, write 0 to mem[cnt], then cnt+1. The cycle that writes address 2^dm_addr_width-1 moves the FSM to READY. busy_o = 1 in CLEAR. en_i is ignored, with no error and no load pipeline entry.
- READY: busy_o = 0. The FSM leaves READY only on rst.
- Store (en_i & we_i & ~re_i): mem[addr] <= data at the sampling edge. Produces no output.
- Load (en_i & re_i & ~we_i): enters a two-stage pipeline. Stage 1 is the BRAM read register, stage 2 is the output register. The tag and valid travel alongside the data.
- en_i with both we_i and re_i set: no access is performed, and err_o pulses the next cycle. en_i with neither set is a no-op.
- Read-after-write: a load to an address written by a store on any earlier edge returns the new data. No forwarding path is needed, because the write lands before the read edge.
- Memory contents are not reset by rst itself. Only the clear sequence zeroes them.
- Address arithmetic: the full address space is valid and there is no out-of-range case. The clear counter is dm_addr_width+1 bits wide so that its terminal detect does not wrap.

## Timing
- Reset values: load_data_o = 0, load_valid_o = 0, load_dest_o = 0, err_o = 0, busy_o = 1. Both pipeline valid bits are 0.
- Clear length: busy_o stays high for exactly 2^dm_addr_width cycles after the first cycle with rst low. The first access is accepted in the cycle busy_o is first low.
- Load latency: a load sampled on edge N has load_valid_o = 1 after edge N+2, for one cycle.
- Throughput: one access per cycle. Back-to-back loads produce back-to-back load_valid_o pulses in issue order.
- err_o: asserted after edge N+1 for an illegal command sampled on edge N.
- Reset mid-operation: rst kills in-flight loads, so no load_valid_o appears after it. It also restarts the clear from address 0. Asserting rst mid-clear restarts the clear from address 0.
- There is no backpressure. Writeback must accept a load_valid_o in any cycle.

## Test plan
Run with dm_addr_width = 4.
- Clear and reset values: hold rst for 3 cycles, then release. busy_o must stay high for 16 cycles. Then load every address: each must return 0, with 16 consecutive valid pulses.
- Store then load: write 0xDEADBEEF to addr 5, then load addr 5 on the next cycle with dest 7. load_valid_o must rise 2 cycles after the load, carrying data 0xDEADBEEF and dest 7.
- Pipelined loads: after storing addr i = i*0x11 for i = 0..3, load addrs 3,2,1,0 on consecutive cycles with dest 1..4. Four consecutive pulses must return 0x33/1, 0x22/2, 0x11/3, 0x00/4.
- Illegal command: en_i, we_i and re_i all set, addr 2, data 0xFF. err_o must pulse once, with no load_valid_o. A later load of addr 2 must return its prior value.
- Reset mid-operation: issue a load, then assert rst on the next edge. No load_valid_o may appear, and busy_o must be high again for 16 cycles. Assert rst again mid-clear at cnt = 9: the clear restarts and takes 16 full cycles. Afterwards, a load of a previously written address must return 0.
- Access during clear: drive en_i with a store to addr 3 of 0xAA while busy_o is high. The store must be dropped and err_o must stay low. After the clear, addr 3 must read 0.
